// File: rtl/sign_mem_dump.sv
// rtl/sign_mem_dump.sv - signature SRAM readout sequencer with stream output and rotate-XOR checksum
module sign_mem_dump #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              reset_d,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_last_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_smem_ext,
    output logic              o_smem_cen,
    output logic              o_smem_wen,
    output logic [ADDR_W-1:0] o_smem_addr,
    output logic [DATA_W-1:0] o_smem_wdata,
    input  logic [DATA_W-1:0] i_smem_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_q0;
    logic [DATA_W-1:0] fifo_q1;
    logic [DATA_W-1:0] chk;
    logic              pop;
    logic              push;
    logic              issue;
    logic              start_ok;
    logic [2:0]        occ_after;

    // A beat leaves the FIFO whenever the head is valid and the sink takes it.
    assign pop      = (fifo_count != 2'd0) & i_ready;
    // Read data returns exactly one cycle after the read, so in-flight means push now.
    assign push     = inflight;
    // Occupancy seen by the next read: buffered + returning - leaving this cycle.
    assign occ_after = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign start_ok = (state == S_IDLE) & i_start;

    assign o_smem_cen   = ~issue;
    assign o_smem_wen   = 1'b1;
    assign o_smem_addr  = rd_addr;
    assign o_smem_wdata = '0;
    assign o_busy       = (state != S_IDLE);
    assign o_valid      = (fifo_count != 2'd0);
    assign o_data       = fifo_q0;
    assign o_checksum   = chk;

    // State register.
    always_ff @(posedge i_clk or negedge reset_d) begin
        if (!reset_d) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read issue and SRAM ownership; the last read is detected by
    // address compare at issue time so a full 2^ADDR_W dump never relies on wrap.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        o_smem_ext = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                o_smem_ext = 1'b1;
                if (occ_after < 3'd2) begin
                    issue = 1'b1;
                    if (rd_addr == last_addr) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                o_smem_ext = 1'b1;
                if ((fifo_count == 2'd0) && !inflight) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read address and dump limit; both are frozen once the dump is running.
    always_ff @(posedge i_clk or negedge reset_d) begin
        if (!reset_d) begin
            rd_addr   <= '0;
            last_addr <= '0;
        end else if (start_ok) begin
            rd_addr   <= '0;
            last_addr <= i_last_addr;
        end else if (issue) begin
            rd_addr   <= rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // In-flight flag marks the cycle in which SRAM read data is valid.
    always_ff @(posedge i_clk or negedge reset_d) begin
        if (!reset_d) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Two-entry shift FIFO; q0 is always the head so o_data comes straight from a flop.
    always_ff @(posedge i_clk or negedge reset_d) begin
        if (!reset_d) begin
            fifo_count <= 2'd0;
            fifo_q0    <= '0;
            fifo_q1    <= '0;
        end else begin
            if (push && pop) begin
                if (fifo_count == 2'd1) begin
                    fifo_q0 <= i_smem_rdata;
                end else begin
                    fifo_q0 <= fifo_q1;
                    fifo_q1 <= i_smem_rdata;
                end
            end else if (pop) begin
                fifo_q0    <= fifo_q1;
                fifo_count <= fifo_count - 2'd1;
            end else if (push) begin
                if (fifo_count == 2'd0) begin
                    fifo_q0 <= i_smem_rdata;
                end else begin
                    fifo_q1 <= i_smem_rdata;
                end
                fifo_count <= fifo_count + 2'd1;
            end
        end
    end

    // Running rotate-left-then-XOR checksum over every delivered beat.
    always_ff @(posedge i_clk or negedge reset_d) begin
        if (!reset_d) begin
            chk <= '0;
        end else if (start_ok) begin
            chk <= '0;
        end else if (pop) begin
            chk <= {chk[DATA_W-2:0], chk[DATA_W-1]} ^ fifo_q0;
        end
    end

    // The issue throttle must keep a push into a full FIFO impossible.
    always @(posedge i_clk) begin
        if (reset_d) begin
            assert (!(push && !pop && (fifo_count == 2'd2)));
        end
    end

endmodule
